// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x5 matrix keypad scanner with column sync and frame debounce
// Scans one row per SETTLE cycles; keys updates once a full frame repeats DEBOUNCE times.
module keypad_scan #(
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  col,
  output logic [3:0]  row,
  output logic [19:0] keys,
  output logic        frame_done
);

  localparam int CW = $clog2(SETTLE);
  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE);

  logic [4:0]    col_m;
  logic [4:0]    col_s;
  logic [1:0]    r;
  logic [CW-1:0] cnt;
  logic [19:0]   frame;
  logic [19:0]   frame_cap;
  logic [19:0]   cand;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nxt;
  logic          capture;
  logic          frame_end;

  // frame_cap is the buffer with the current row's columns merged in, so at
  // row 3 it is already the complete new frame.
  always_comb begin
    capture   = (cnt == CNT_LAST);
    frame_end = capture && (r == 2'd3);
    frame_cap = frame;
    case (r)
      2'd0: frame_cap[4:0]   = col_s;
      2'd1: frame_cap[9:5]   = col_s;
      2'd2: frame_cap[14:10] = col_s;
      default: frame_cap[19:15] = col_s;
    endcase
    match_nxt = (match_cnt >= MATCH_MAX) ? MATCH_MAX : match_cnt + MW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m      <= '0;
      col_s      <= '0;
      r          <= '0;
      cnt        <= '0;
      row        <= 4'b0001;
      frame      <= '0;
      cand       <= '0;
      match_cnt  <= MATCH_MAX;
      keys       <= '0;
      frame_done <= 1'b0;
    end else begin
      col_m      <= col;
      col_s      <= col_m;
      frame_done <= frame_end;

      if (capture) begin
        frame <= frame_cap;
        r     <= r + 2'd1;
        cnt   <= '0;
        row   <= {row[2:0], row[3]};
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Any differing frame restarts the count; keys only follows a stable candidate.
      if (frame_end) begin
        if (frame_cap != cand) begin
          cand      <= frame_cap;
          match_cnt <= MW'(1);
          if (DEBOUNCE == 1) keys <= frame_cap;
        end else begin
          match_cnt <= match_nxt;
          if (match_nxt == MATCH_MAX) keys <= cand;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan
// A behavioural key matrix drives col from row and the pressed-key vectors.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  col, col1;
  logic [3:0]  row, row1;
  logic [19:0] keys, keys1;
  logic        frame_done, frame_done1;
  logic [19:0] pressed  = '0;
  logic [19:0] pressed1 = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SETTLE(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .keys(keys), .frame_done(frame_done)
  );

  keypad_scan #(.SETTLE(4), .DEBOUNCE(1)) dut1 (
    .clk(clk), .rst(rst), .col(col1), .row(row1), .keys(keys1), .frame_done(frame_done1)
  );

  always_comb begin
    col  = '0;
    col1 = '0;
    for (int i = 0; i < 4; i++) begin
      if (row[i])  col  = col  | pressed[i*5 +: 5];
      if (row1[i]) col1 = col1 | pressed1[i*5 +: 5];
    end
  end

  task automatic wait_frame(input bit which, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? frame_done1 : frame_done) && n < 40);
    checks++;
    if (!(which ? frame_done1 : frame_done)) begin
      errors++;
      $display("FAIL frame_timeout: dut%0d no frame_done after %0d cycles, required within 40", which, n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (row !== 4'b0001) begin errors++; $display("FAIL reset_row: got %b required 0001", row); end
    checks++; if (keys !== 20'h0) begin errors++; $display("FAIL reset_keys: got %h required 00000", keys); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    rst = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      exp_row = 4'(1 << ((k / 4) % 4));
      checks++;
      if (row !== exp_row) begin errors++; $display("FAIL scan_row: cycle %0d got %b required %b", k, row, exp_row); end
      checks++;
      if (frame_done !== (k % 16 == 0)) begin
        errors++; $display("FAIL scan_frame_done: cycle %0d got %b required %b", k, frame_done, (k % 16 == 0));
      end
      checks++;
      if (keys !== 20'h0) begin errors++; $display("FAIL scan_keys: cycle %0d got %h required 00000", k, keys); end
    end
  endtask

  task automatic test_single_key();
    int n;
    logic [19:0] exp;
    wait_frame(0, n);
    pressed = 20'h00080;
    for (int f = 1; f <= 3; f++) begin
      wait_frame(0, n);
      exp = (f == 3) ? 20'h00080 : 20'h0;
      checks++;
      if (keys !== exp) begin errors++; $display("FAIL press_key7: frame %0d got %h required %h", f, keys, exp); end
    end
    pressed = 20'h0;
    for (int f = 1; f <= 3; f++) begin
      wait_frame(0, n);
      exp = (f == 3) ? 20'h0 : 20'h00080;
      checks++;
      if (keys !== exp) begin errors++; $display("FAIL release_key7: frame %0d got %h required %h", f, keys, exp); end
    end
  endtask

  task automatic test_bounce();
    int n;
    pressed = 20'h00080;
    wait_frame(0, n);
    pressed = 20'h0;
    for (int f = 1; f <= 4; f++) begin
      wait_frame(0, n);
      checks++;
      if (keys !== 20'h0) begin errors++; $display("FAIL bounce_press: frame %0d got %h required 00000", f, keys); end
    end
    pressed = 20'h00080;
    repeat (3) wait_frame(0, n);
    checks++;
    if (keys !== 20'h00080) begin errors++; $display("FAIL bounce_settle: got %h required 00080", keys); end
    pressed = 20'h0;
    wait_frame(0, n);
    pressed = 20'h00080;
    for (int f = 1; f <= 4; f++) begin
      wait_frame(0, n);
      checks++;
      if (keys !== 20'h00080) begin errors++; $display("FAIL bounce_release: frame %0d got %h required 00080", f, keys); end
    end
    pressed = 20'h0;
    repeat (3) wait_frame(0, n);
    checks++;
    if (keys !== 20'h0) begin errors++; $display("FAIL bounce_clear: got %h required 00000", keys); end
  endtask

  task automatic test_corners();
    int n;
    logic [19:0] exp;
    pressed = 20'h80001;
    for (int f = 1; f <= 3; f++) begin
      wait_frame(0, n);
      exp = (f == 3) ? 20'h80001 : 20'h0;
      checks++;
      if (keys !== exp) begin errors++; $display("FAIL corners_press: frame %0d got %h required %h", f, keys, exp); end
    end
    pressed = 20'h80000;
    for (int f = 1; f <= 3; f++) begin
      wait_frame(0, n);
      exp = (f == 3) ? 20'h80000 : 20'h80001;
      checks++;
      if (keys !== exp) begin errors++; $display("FAIL corners_release0: frame %0d got %h required %h", f, keys, exp); end
    end
    pressed = 20'h0;
    repeat (3) wait_frame(0, n);
    checks++;
    if (keys !== 20'h0) begin errors++; $display("FAIL corners_clear: got %h required 00000", keys); end
  endtask

  task automatic test_reset_mid();
    int n;
    int w;
    logic [19:0] exp;
    pressed = 20'h00080;
    repeat (3) wait_frame(0, n);
    checks++;
    if (keys !== 20'h00080) begin errors++; $display("FAIL midrst_pre: got %h required 00080", keys); end
    w = 0;
    while (row !== 4'b0100 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (row !== 4'b0100) begin errors++; $display("FAIL midrst_row2_timeout: got %b required 0100", row); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (keys !== 20'h0) begin errors++; $display("FAIL midrst_keys: got %h required 00000", keys); end
    checks++; if (row !== 4'b0001) begin errors++; $display("FAIL midrst_row: got %b required 0001", row); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      wait_frame(0, n);
      if (f == 1) begin
        checks++;
        if (n !== 16) begin errors++; $display("FAIL midrst_first_frame: got %0d cycles required 16", n); end
      end
      exp = (f == 3) ? 20'h00080 : 20'h0;
      checks++;
      if (keys !== exp) begin errors++; $display("FAIL midrst_repress: frame %0d got %h required %h", f, keys, exp); end
    end
    pressed = 20'h0;
  endtask

  task automatic test_debounce1();
    int n;
    wait_frame(1, n);
    for (int i = 0; i < 3; i++) begin
      pressed1 = 20'h00020;
      wait_frame(1, n);
      checks++;
      if (keys1 !== 20'h00020) begin errors++; $display("FAIL deb1_key5: iter %0d got %h required 00020", i, keys1); end
      pressed1 = 20'h01000;
      wait_frame(1, n);
      checks++;
      if (keys1 !== 20'h01000) begin errors++; $display("FAIL deb1_key12: iter %0d got %h required 01000", i, keys1); end
    end
    pressed1 = 20'h01000;
    wait_frame(1, n);
    checks++;
    if (keys1 !== 20'h01000) begin errors++; $display("FAIL deb1_hold: got %h required 01000", keys1); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_key();
    test_bounce();
    test_corners();
    test_reset_mid();
    test_debounce1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
